// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : pwm_duty_sequencer
//  Purpose  : Upstream driver for a PWM stage. Divides clk into a one-cycle
//             step strobe and produces a duty word that either breathes as
//             a triangle ramp (with dwell at both extremes) or slews one LSB
//             per update toward an external target. Duty only changes once
//             per full PWM period (UPDATE_STEPS steps).
//  Ports    : clk          - system clock
//             rst          - asynchronous reset, active low
//             ena          - advance enable; low freezes everything
//             mode         - 0 breathe, 1 track target (sampled on updates)
//             target [N]   - track-mode goal duty (sampled on updates)
//             step         - one-clk strobe every PRESCALE enabled clks
//             duty [N]     - registered duty word
//             period_done  - high in the cycle of an update event
//             phase [3]    - RISE=0 HOLD_HI=1 FALL=2 HOLD_LO=3 TRACK=4
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer #(
    parameter int N            = 8,
    parameter int PRESCALE     = 256,
    parameter int UPDATE_STEPS = 256,
    parameter int HOLD         = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         mode,
    input  logic [N-1:0] target,
    output logic         step,
    output logic [N-1:0] duty,
    output logic         period_done,
    output logic [2:0]   phase
);

    localparam int PRE_W  = $clog2(PRESCALE);
    localparam int STEP_W = (UPDATE_STEPS > 1) ? $clog2(UPDATE_STEPS) : 1;
    localparam int HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    localparam logic [PRE_W-1:0]  C_PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0] C_STEP_LAST = STEP_W'(UPDATE_STEPS - 1);
    // With HOLD=0 the dwell states are never entered, so this value is unused.
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [N-1:0]      C_DUTY_MAX  = {N{1'b1}};

    typedef enum logic [2:0] {
        RISE    = 3'd0,
        HOLD_HI = 3'd1,
        FALL    = 3'd2,
        HOLD_LO = 3'd3,
        TRACK   = 3'd4
    } phase_e;

    logic [PRE_W-1:0]  pre_cnt_q,  pre_cnt_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]      duty_q,     duty_d;
    phase_e            phase_q,    phase_d;

    logic w_step;
    logic w_upd;

    // Strobes depend only on registered counts and ena, never on mode/target.
    assign w_step = ena && (pre_cnt_q == C_PRE_LAST);
    assign w_upd  = w_step && (step_cnt_q == C_STEP_LAST);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q  <= '0;
            step_cnt_q <= '0;
            hold_cnt_q <= '0;
            duty_q     <= '0;
            phase_q    <= RISE;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            step_cnt_q <= step_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            duty_q     <= duty_d;
            phase_q    <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and step counter
    // ------------------------------------------------------------------
    always_comb begin
        pre_cnt_d  = pre_cnt_q;
        step_cnt_d = step_cnt_q;
        if (ena) begin
            pre_cnt_d = (pre_cnt_q == C_PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
        end
        if (w_step) begin
            step_cnt_d = (step_cnt_q == C_STEP_LAST) ? '0 : step_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Phase / duty next-state, evaluated only on update events
    // ------------------------------------------------------------------
    always_comb begin
        phase_d    = phase_q;
        duty_d     = duty_q;
        hold_cnt_d = hold_cnt_q;
        if (w_upd) begin
            if (mode) begin
                // Track: single-LSB slew, stops exactly on target.
                phase_d = TRACK;
                if (duty_q < target) begin
                    duty_d = duty_q + 1'b1;
                end else if (duty_q > target) begin
                    duty_d = duty_q - 1'b1;
                end
            end else begin
                unique case (phase_q)
                    TRACK: begin
                        // Re-enter breathing from the current duty.
                        phase_d = RISE;
                    end
                    RISE: begin
                        if (duty_q < C_DUTY_MAX) begin
                            duty_d = duty_q + 1'b1;
                        end else begin
                            phase_d    = (HOLD > 0) ? HOLD_HI : FALL;
                            hold_cnt_d = '0;
                        end
                    end
                    HOLD_HI: begin
                        if (hold_cnt_q == C_HOLD_LAST) begin
                            phase_d = FALL;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    FALL: begin
                        if (duty_q > '0) begin
                            duty_d = duty_q - 1'b1;
                        end else begin
                            phase_d    = (HOLD > 0) ? HOLD_LO : RISE;
                            hold_cnt_d = '0;
                        end
                    end
                    HOLD_LO: begin
                        if (hold_cnt_q == C_HOLD_LAST) begin
                            phase_d = RISE;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        phase_d = RISE;
                    end
                endcase
            end
        end
    end

    assign step        = w_step;
    assign period_done = w_upd;
    assign duty        = duty_q;
    assign phase       = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pwm_duty_sequencer
//  Purpose  : Self-checking bench for pwm_duty_sequencer. A main instance
//             (N=3, PRESCALE=4, UPDATE_STEPS=8, HOLD=2) is compared every
//             cycle against an arithmetic reference model, with tabulated
//             per-update expectations; a second instance (N=2, HOLD=0)
//             covers the no-dwell ramp.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_sequencer;

    localparam int N    = 3;
    localparam int P    = 4;
    localparam int U    = 8;
    localparam int H    = 2;
    localparam int MAXD = (1 << N) - 1;
    localparam int PER  = P * U;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         mode;
    logic [N-1:0] target;
    logic         step;
    logic [N-1:0] duty;
    logic         period_done;
    logic [2:0]   phase;

    logic         rst2;
    logic         step2;
    logic [1:0]   duty2;
    logic         pd2;
    logic [2:0]   phase2;

    always #5 clk = ~clk;

    pwm_duty_sequencer #(.N(N), .PRESCALE(P), .UPDATE_STEPS(U), .HOLD(H)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .mode        (mode),
        .target      (target),
        .step        (step),
        .duty        (duty),
        .period_done (period_done),
        .phase       (phase)
    );

    pwm_duty_sequencer #(.N(2), .PRESCALE(4), .UPDATE_STEPS(8), .HOLD(0)) u_dut_h0 (
        .clk         (clk),
        .rst         (rst2),
        .ena         (1'b1),
        .mode        (1'b0),
        .target      (2'b00),
        .step        (step2),
        .duty        (duty2),
        .period_done (pd2),
        .phase       (phase2)
    );

    typedef struct {
        bit mode;
        int target;
        int duty;
        int phase;
    } vec_t;

    vec_t brt [21];
    vec_t trk [8];
    vec_t swp [6];
    vec_t h0  [9];

    int checks = 0;
    int errors = 0;

    // Reference model: enabled-cycle position inside one PWM period plus
    // the abstract breathe/track state.
    int m_en, m_duty, m_phase, m_hold;
    int cyc, first_step, first_pd, ncyc;
    bit last_pd, last_step;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_duty = 0; m_phase = 0; m_hold = 0;
    endtask

    task automatic model_update(input bit m, input int t);
        if (m) begin
            m_phase = 4;
            if (m_duty < t) m_duty++;
            else if (m_duty > t) m_duty--;
        end else begin
            case (m_phase)
                4: m_phase = 0;
                0: if (m_duty < MAXD) m_duty++;
                   else begin m_phase = (H > 0) ? 1 : 2; m_hold = 0; end
                1: if (m_hold == H - 1) m_phase = 2; else m_hold++;
                2: if (m_duty > 0) m_duty--;
                   else begin m_phase = (H > 0) ? 3 : 0; m_hold = 0; end
                3: if (m_hold == H - 1) m_phase = 0; else m_hold++;
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock cycle: called just after a falling edge, returns just after
    // the next falling edge.
    task automatic run_cycle(input bit e, input bit m, input int t);
        bit es, eu;
        ena    = e;
        mode   = m;
        target = N'(t);
        #1;
        es = e && (m_en % P == P - 1);
        eu = e && (m_en % PER == PER - 1);
        cyc++;
        chk("step",        int'(step),        int'(es));
        chk("period_done", int'(period_done), int'(eu));
        chk("duty",        int'(duty),        m_duty);
        chk("phase",       int'(phase),       m_phase);
        if (step && first_step == 0) first_step = cyc;
        if (period_done && first_pd == 0) first_pd = cyc;
        last_pd   = period_done;
        last_step = step;
        @(posedge clk);
        if (e) begin
            if (eu) model_update(m, t);
            m_en = (m_en + 1) % PER;
        end
        @(negedge clk);
    endtask

    // Run enabled cycles until an update event has been clocked in. With
    // scramble set, mode/target are randomised on every non-update cycle.
    task automatic run_to_update(input bit m, input int t, input bit scramble);
        bit got;
        bit mm;
        int tt;
        got  = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            mm = m;
            tt = t;
            if (scramble && (m_en % PER != PER - 1)) begin
                mm = ($urandom_range(0, 1) == 1);
                tt = int'($urandom_range(0, MAXD));
            end
            run_cycle(1'b1, mm, tt);
            ncyc++;
            got = last_pd;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL update_timeout: period_done not seen in 200 cycles");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        bit rmode;
        int cnt, bad;
        bit got;

        // ---------------- expectation tables ----------------
        for (int i = 0; i < 7; i++) brt[i] = '{1'b0, 0, i + 1, 0};
        brt[7] = '{1'b0, 0, 7, 1};
        brt[8] = '{1'b0, 0, 7, 1};
        brt[9] = '{1'b0, 0, 7, 2};
        for (int i = 10; i < 17; i++) brt[i] = '{1'b0, 0, 16 - i, 2};
        brt[17] = '{1'b0, 0, 0, 3};
        brt[18] = '{1'b0, 0, 0, 3};
        brt[19] = '{1'b0, 0, 0, 0};
        brt[20] = '{1'b0, 0, 1, 0};

        trk[0] = '{1'b1, 5, 3, 4};
        trk[1] = '{1'b1, 5, 4, 4};
        trk[2] = '{1'b1, 5, 5, 4};
        trk[3] = '{1'b1, 5, 5, 4};
        trk[4] = '{1'b1, 1, 4, 4};
        trk[5] = '{1'b1, 1, 3, 4};
        trk[6] = '{1'b1, 1, 2, 4};
        trk[7] = '{1'b1, 1, 1, 4};

        swp[0] = '{1'b0, 0, 6, 0};
        swp[1] = '{1'b0, 0, 7, 0};
        swp[2] = '{1'b0, 0, 7, 1};
        swp[3] = '{1'b0, 0, 7, 1};
        swp[4] = '{1'b0, 0, 7, 2};
        swp[5] = '{1'b0, 0, 6, 2};

        h0[0] = '{1'b0, 0, 1, 0};
        h0[1] = '{1'b0, 0, 2, 0};
        h0[2] = '{1'b0, 0, 3, 0};
        h0[3] = '{1'b0, 0, 3, 2};
        h0[4] = '{1'b0, 0, 2, 2};
        h0[5] = '{1'b0, 0, 1, 2};
        h0[6] = '{1'b0, 0, 0, 2};
        h0[7] = '{1'b0, 0, 0, 0};
        h0[8] = '{1'b0, 0, 1, 0};

        // ---------------- reset ----------------
        rst = 1'b1; rst2 = 1'b0; ena = 1'b0; mode = 1'b0; target = '0;
        first_step = 0; first_pd = 0; cyc = 0;
        #1 rst = 1'b0;
        #1;
        chk("reset_step",  int'(step),        0);
        chk("reset_pd",    int'(period_done), 0);
        chk("reset_duty",  int'(duty),        0);
        chk("reset_phase", int'(phase),       0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // ---------------- breathe from reset ----------------
        for (int i = 0; i < 21; i++) begin
            run_to_update(1'b0, 0, 1'b0);
            chk($sformatf("breathe%0d_duty", i + 1),  int'(duty),  brt[i].duty);
            chk($sformatf("breathe%0d_phase", i + 1), int'(phase), brt[i].phase);
        end
        chk("first_step_cycle", first_step, 4);
        chk("first_pd_cycle",   first_pd,   32);

        // ---------------- freeze with ena low ----------------
        for (int i = 0; i < 3; i++) run_to_update(1'b0, 0, 1'b0);
        chk("pre_freeze_duty", int'(duty), 4);
        run_cycle(1'b1, 1'b0, 0);
        run_cycle(1'b1, 1'b0, 0);
        sc = 0;
        for (int i = 0; i < 50; i++) begin
            run_cycle(1'b0, ($urandom_range(0, 1) == 1), int'($urandom_range(0, MAXD)));
            if (last_step || last_pd) sc++;
        end
        chk("freeze_strobes", sc, 0);
        chk("freeze_duty",  int'(duty),  4);
        chk("freeze_phase", int'(phase), 0);
        run_cycle(1'b1, 1'b0, 0);
        chk("resume_c1_step", int'(last_step), 0);
        run_cycle(1'b1, 1'b0, 0);
        chk("resume_c2_step", int'(last_step), 1);
        run_to_update(1'b0, 0, 1'b0);
        chk("resume_cycles_to_update", ncyc, 28);
        chk("resume_duty", int'(duty), 5);

        // ---------------- track mode ----------------
        for (int i = 0; i < 3; i++) run_to_update(1'b1, 2, 1'b0);
        chk("track_pre_duty",  int'(duty),  2);
        chk("track_pre_phase", int'(phase), 4);
        for (int i = 0; i < 8; i++) begin
            run_to_update(trk[i].mode, trk[i].target, 1'b1);
            chk($sformatf("track%0d_duty", i + 1),  int'(duty),  trk[i].duty);
            chk($sformatf("track%0d_phase", i + 1), int'(phase), trk[i].phase);
        end

        // ---------------- track -> breathe, then reset mid-FALL ----------------
        for (int i = 0; i < 5; i++) run_to_update(1'b1, 6, 1'b1);
        chk("swap_pre_duty", int'(duty), 6);
        for (int i = 0; i < 6; i++) begin
            run_to_update(swp[i].mode, swp[i].target, 1'b0);
            chk($sformatf("swap%0d_duty", i + 1),  int'(duty),  swp[i].duty);
            chk($sformatf("swap%0d_phase", i + 1), int'(phase), swp[i].phase);
        end
        for (int i = 0; i < 8 && (m_en % P != P - 1); i++) run_cycle(1'b1, 1'b0, 0);
        ena = 1'b1; mode = 1'b0;
        #1;
        chk("pre_rst_step", int'(step), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_step",  int'(step),        0);
        chk("async_rst_pd",    int'(period_done), 0);
        chk("async_rst_duty",  int'(duty),        0);
        chk("async_rst_phase", int'(phase),       0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // ---------------- randomised run against the model ----------------
        rmode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) rmode = ~rmode;
            run_cycle(($urandom_range(0, 9) != 0), rmode, int'($urandom_range(0, MAXD)));
        end

        // ---------------- HOLD=0, N=2 instance ----------------
        ena = 1'b0;
        rst2 = 1'b1;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            got = 1'b0;
            cnt = 0;
            for (int j = 0; j < 100 && !got; j++) begin
                #1;
                cnt++;
                if (phase2 == 3'd1 || phase2 == 3'd3) bad++;
                if (pd2) got = 1'b1;
                @(negedge clk);
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL h0_timeout: period_done not seen in 100 cycles");
            end else begin
                #1;
                chk($sformatf("h0_%0d_period", i + 1), cnt, 32);
                chk($sformatf("h0_%0d_duty", i + 1),  int'(duty2),  h0[i].duty);
                chk($sformatf("h0_%0d_phase", i + 1), int'(phase2), h0[i].phase);
            end
        end
        chk("h0_dwell_phases_seen", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
